// File: rtl/hwpe_stream_copy_source_delayed_pkg.sv
// Shared constants and helpers for the delayed copy-source checker.
// The counter helper lets any counter width up to 32 bits reuse one saturating increment.
package hwpe_stream_copy_source_delayed_pkg;

    localparam int unsigned COPY_MAX_DELAY = 16;

    // Increment without wrapping; the limit is 2**width - 1.
    function automatic logic [31:0] copy_sat_inc(input logic [31:0] cnt,
                                                 input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (cnt >= max_val) ? max_val : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/hwpe_stream_copy_source_delayed_if.sv
// HWPE stream bundle (valid/ready/data/strb) used by the normal and copy networks.
interface hwpe_stream_copy_source_delayed_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source  (output valid, data, strb, input ready);
    modport sink    (input valid, data, strb, output ready);
    modport monitor (input valid, ready, data, strb);
endinterface

// File: rtl/hwpe_stream_copy_delay_line.sv
// DEPTH-stage free-running shift register; only the oldest stage is visible.
module hwpe_stream_copy_delay_line #(
    parameter int unsigned DEPTH  = 1,
    parameter type         slot_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clear_i,
    input  slot_t slot_i,
    output slot_t slot_o
);

    slot_t stage_q [DEPTH];
    slot_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = slot_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign slot_o = stage_q[DEPTH-1];

endmodule

// File: rtl/hwpe_stream_copy_source_delayed.sv
// Drives a DELAY-cycle-shifted replica of a monitored stream into a copy network and flags
// any cycle where the copy ready disagrees with the equally delayed normal ready.
module hwpe_stream_copy_source_delayed
    import hwpe_stream_copy_source_delayed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DELAY      = 1,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    hwpe_stream_copy_source_delayed_if.monitor normal_i,
    hwpe_stream_copy_source_delayed_if.source  copy_o,
    output logic                 fault_detected_o,
    output logic                 fault_sticky_o,
    output logic [CNT_WIDTH-1:0] fault_count_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned LINE_DEPTH = (DELAY > COPY_MAX_DELAY) ? COPY_MAX_DELAY : DELAY;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic                  slot;
        logic [STRB_WIDTH-1:0] strb;
        logic [DATA_WIDTH-1:0] data;
    } copy_slot_t;

    logic mismatch;

    generate
        if (LINE_DEPTH == 0) begin : g_comb
            assign copy_o.valid = normal_i.valid;
            assign copy_o.data  = normal_i.data;
            assign copy_o.strb  = normal_i.strb;
            assign mismatch     = (normal_i.ready != copy_o.ready);
        end else begin : g_delay
            copy_slot_t head;
            copy_slot_t tail;

            always_comb begin
                head.valid = normal_i.valid;
                head.ready = normal_i.ready;
                head.slot  = 1'b1;
                head.strb  = normal_i.strb;
                head.data  = normal_i.data;
            end

            hwpe_stream_copy_delay_line #(
                .DEPTH  (LINE_DEPTH),
                .slot_t (copy_slot_t)
            ) i_delay_line (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .clear_i (clear_i),
                .slot_i  (head),
                .slot_o  (tail)
            );

            assign copy_o.valid = tail.valid;
            assign copy_o.data  = tail.data;
            assign copy_o.strb  = tail.strb;
            // An empty slot means the copy ready is not yet defined, so it is ignored.
            assign mismatch     = tail.slot && (tail.ready != copy_o.ready);
        end
    endgenerate

    logic                 fault_det_d, fault_det_q;
    logic                 fault_sticky_d, fault_sticky_q;
    logic [CNT_WIDTH-1:0] fault_cnt_d, fault_cnt_q;

    always_comb begin
        fault_det_d    = 1'b0;
        fault_sticky_d = fault_sticky_q;
        fault_cnt_d    = fault_cnt_q;
        if (clear_i) begin
            fault_sticky_d = 1'b0;
            fault_cnt_d    = '0;
        end else if (mismatch) begin
            fault_det_d    = 1'b1;
            fault_sticky_d = 1'b1;
            fault_cnt_d    = CNT_WIDTH'(copy_sat_inc(32'(fault_cnt_q), CNT_WIDTH));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_det_q    <= 1'b0;
            fault_sticky_q <= 1'b0;
            fault_cnt_q    <= '0;
        end else begin
            fault_det_q    <= fault_det_d;
            fault_sticky_q <= fault_sticky_d;
            fault_cnt_q    <= fault_cnt_d;
        end
    end

    assign fault_detected_o = fault_det_q;
    assign fault_sticky_o   = fault_sticky_q;
    assign fault_count_o    = fault_cnt_q;

endmodule

// File: tb/tb_hwpe_stream_copy_source_delayed.sv
// Directed bench: DELAY=2/CNT_WIDTH=3 table plus saturation, DELAY=4 mid-stream reset,
// and DELAY=0 combinational copy.
module tb_hwpe_stream_copy_source_delayed;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr2 = 1'b0, clr4 = 1'b0, clr0 = 1'b0;

    always #5 clk = ~clk;

    hwpe_stream_copy_source_delayed_if #(.DATA_WIDTH(32)) n2 ();
    hwpe_stream_copy_source_delayed_if #(.DATA_WIDTH(32)) c2 ();
    hwpe_stream_copy_source_delayed_if #(.DATA_WIDTH(32)) n4 ();
    hwpe_stream_copy_source_delayed_if #(.DATA_WIDTH(32)) c4 ();
    hwpe_stream_copy_source_delayed_if #(.DATA_WIDTH(32)) n0 ();
    hwpe_stream_copy_source_delayed_if #(.DATA_WIDTH(32)) c0 ();

    logic       det2, st2;
    logic [2:0] cnt2;
    logic       det4, st4;
    logic [7:0] cnt4;
    logic       det0, st0;
    logic [7:0] cnt0;

    hwpe_stream_copy_source_delayed #(.DATA_WIDTH(32), .DELAY(2), .CNT_WIDTH(3)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr2), .normal_i(n2), .copy_o(c2),
        .fault_detected_o(det2), .fault_sticky_o(st2), .fault_count_o(cnt2)
    );
    hwpe_stream_copy_source_delayed #(.DATA_WIDTH(32), .DELAY(4), .CNT_WIDTH(8)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr4), .normal_i(n4), .copy_o(c4),
        .fault_detected_o(det4), .fault_sticky_o(st4), .fault_count_o(cnt4)
    );
    hwpe_stream_copy_source_delayed #(.DATA_WIDTH(32), .DELAY(0), .CNT_WIDTH(8)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr0), .normal_i(n0), .copy_o(c0),
        .fault_detected_o(det0), .fault_sticky_o(st0), .fault_count_o(cnt0)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        clr, nv, nr, cr;
        logic [31:0] nd;
        logic [3:0]  ns;
        logic        cv;
        logic [31:0] cd;
        logic [3:0]  cs;
        logic        det, st;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mk(logic clr, logic nv, logic nr, logic [31:0] nd, logic cr,
                                logic cv, logic [31:0] cd, logic det, logic st,
                                logic [2:0] cnt);
        vec_t v;
        v.clr = clr; v.nv = nv; v.nr = nr; v.nd = nd; v.ns = nv ? 4'hF : 4'h0; v.cr = cr;
        v.cv = cv; v.cd = cd; v.cs = cv ? 4'hF : 4'h0; v.det = det; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        logic       e_det;
        logic [7:0] e_cnt;

        // Row 0 clears; copy ready mirrors normal ready two rows earlier except
        // for the flip at row 9, the clear race at row 12 and don't-care fill rows.
        tbl[0]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 32'hA5A5_0001, 1, 0, 32'h0,         0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 32'hA5A5_0002, 0, 0, 32'h0,         0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 32'hA5A5_0003, 1, 1, 32'hA5A5_0001, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 32'hA5A5_0004, 0, 1, 32'hA5A5_0002, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 32'h0,         1, 1, 32'hA5A5_0003, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 32'h0,         1, 1, 32'hA5A5_0004, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 32'h0,         1, 0, 32'h0,         0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[10] = mk(0, 0, 1, 32'h0,         1, 0, 32'h0,         1, 1, 1);
        tbl[11] = mk(0, 0, 1, 32'h0,         1, 0, 32'h0,         0, 1, 1);
        tbl[12] = mk(1, 1, 1, 32'hA5A5_0005, 0, 0, 32'h0,         0, 1, 1);
        tbl[13] = mk(0, 1, 1, 32'hA5A5_0006, 0, 0, 32'h0,         0, 0, 0);
        tbl[14] = mk(0, 1, 0, 32'hA5A5_0007, 1, 0, 32'h0,         0, 0, 0);
        tbl[15] = mk(0, 0, 1, 32'h0,         1, 1, 32'hA5A5_0006, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 32'h0,         0, 1, 32'hA5A5_0007, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 0);

        n2.valid = 0; n2.ready = 0; n2.data = '0; n2.strb = '0; c2.ready = 0;
        n4.valid = 0; n4.ready = 0; n4.data = '0; n4.strb = '0; c4.ready = 0;
        n0.valid = 0; n0.ready = 0; n0.data = '0; n0.strb = '0; c0.ready = 0;

        #1 rst_n = 1'b0;
        #2;
        check("rst_c2_valid", 64'(c2.valid), 64'd0);
        check("rst_c2_data", 64'(c2.data), 64'd0);
        check("rst_det2", 64'(det2), 64'd0);
        check("rst_st2", 64'(st2), 64'd0);
        check("rst_cnt2", 64'(cnt2), 64'd0);
        check("rst_c4_valid", 64'(c4.valid), 64'd0);
        check("rst_cnt4", 64'(cnt4), 64'd0);
        check("rst_cnt0", 64'(cnt0), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) next();

        for (int i = 0; i < 18; i++) begin
            clr2 = tbl[i].clr;
            n2.valid = tbl[i].nv; n2.ready = tbl[i].nr;
            n2.data = tbl[i].nd; n2.strb = tbl[i].ns;
            c2.ready = tbl[i].cr;
            #4;
            check($sformatf("tbl%0d_cvalid", i), 64'(c2.valid), 64'(tbl[i].cv));
            check($sformatf("tbl%0d_cdata", i), 64'(c2.data), 64'(tbl[i].cd));
            check($sformatf("tbl%0d_cstrb", i), 64'(c2.strb), 64'(tbl[i].cs));
            check($sformatf("tbl%0d_det", i), 64'(det2), 64'(tbl[i].det));
            check($sformatf("tbl%0d_sticky", i), 64'(st2), 64'(tbl[i].st));
            check($sformatf("tbl%0d_cnt", i), 64'(cnt2), 64'(tbl[i].cnt));
            next();
        end

        // Saturation: 12 mismatch cycles (k=2..13) into a 3-bit counter.
        clr2 = 1'b1; n2.valid = 0; n2.ready = 0; n2.data = '0; n2.strb = '0; c2.ready = 0;
        next();
        clr2 = 1'b0;
        n2.ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            c2.ready = (k >= 14);
            #4;
            e_det = (k >= 3 && k <= 14);
            e_cnt = (k < 3) ? 8'd0 : ((k - 2 > 7) ? 8'd7 : 8'(k - 2));
            check($sformatf("sat%0d_det", k), 64'(det2), 64'(e_det));
            check($sformatf("sat%0d_cnt", k), 64'(cnt2), 64'(e_cnt));
            check($sformatf("sat%0d_sticky", k), 64'(st2), 64'(k >= 3));
            next();
        end
        n2.ready = 1'b0; c2.ready = 1'b0;

        // DELAY=4: four beats in flight, then reset mid-stream.
        for (int b = 0; b < 4; b++) begin
            n4.valid = 1'b1; n4.ready = 1'b1; n4.data = 32'hB0B0_0000 + 32'(b); n4.strb = 4'hF;
            c4.ready = 1'b0;
            next();
        end
        n4.valid = 1'b0; n4.data = '0; n4.strb = '0;
        #1;
        check("d4_inflight_valid", 64'(c4.valid), 64'd1);
        check("d4_inflight_data", 64'(c4.data), 64'hB0B0_0000);
        check("d4_inflight_cnt", 64'(cnt4), 64'd0);
        rst_n = 1'b0;
        #1;
        check("d4_rst_valid", 64'(c4.valid), 64'd0);
        check("d4_rst_data", 64'(c4.data), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Garbage copy ready (1 vs an all-zero history) during fill must not fault.
        c4.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #3;
            check($sformatf("d4_fill%0d_det", k), 64'(det4), 64'd0);
            check($sformatf("d4_fill%0d_cvalid", k), 64'(c4.valid), 64'd0);
            next();
        end
        check("d4_fill_cnt", 64'(cnt4), 64'd0);
        check("d4_fill_sticky", 64'(st4), 64'd0);

        // DELAY=0: combinational copy, mismatch at k=5 pulses at k=6.
        for (int k = 0; k < 8; k++) begin
            n0.valid = k[0]; n0.ready = k[1];
            n0.data = 32'hC0DE_0000 + 32'(k); n0.strb = 4'(k);
            c0.ready = (k == 5) ? ~k[1] : k[1];
            #3;
            check($sformatf("d0_%0d_valid", k), 64'(c0.valid), 64'(k[0]));
            check($sformatf("d0_%0d_data", k), 64'(c0.data), 64'(32'hC0DE_0000 + 32'(k)));
            check($sformatf("d0_%0d_strb", k), 64'(c0.strb), 64'(k[3:0]));
            check($sformatf("d0_%0d_det", k), 64'(det0), 64'(k == 6));
            check($sformatf("d0_%0d_cnt", k), 64'(cnt0), 64'(k >= 6));
            next();
        end
        check("d0_sticky", 64'(st0), 64'd1);
        clr0 = 1'b1; n0.ready = 1'b1; c0.ready = 1'b0;
        next();
        clr0 = 1'b0; c0.ready = 1'b1; n0.valid = 1'b1; n0.data = 32'h1234_5678;
        #3;
        check("d0_clr_det", 64'(det0), 64'd0);
        check("d0_clr_cnt", 64'(cnt0), 64'd0);
        check("d0_clr_sticky", 64'(st0), 64'd0);
        check("d0_clr_valid", 64'(c0.valid), 64'd1);
        check("d0_clr_data", 64'(c0.data), 64'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
